// File: rtl/hs_resp_slave_pkg.sv
// Shared types, response codes and parity helper for the hs_resp_slave slice.
package hs_pkg;
  typedef logic [1:0]  resp_t;
  typedef logic [31:0] hs_word_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_SLVERR = 2'b10;

  function automatic logic even_par(hs_word_t w);
    return ^w;
  endfunction
endpackage

// File: rtl/hs_resp_slave_if.sv
// Forward data channel plus response return path; parity pins exist only
// when HS_RESP_PARITY_EN is defined.
interface hs_resp_slave_if #(parameter int DEPTH = 4);
  import hs_pkg::*;
  localparam int CW = $clog2(DEPTH) + 1;

  hs_word_t        data;
  logic            valid;
  logic            ready;
  hs_word_t        resp_data;
  resp_t           resp_code;
  logic            resp_valid;
  logic            resp_ready;
  logic [CW-1:0]   resp_count;
`ifdef HS_RESP_PARITY_EN
  logic            data_par;
  logic            resp_par;

  modport master (output data, valid, resp_ready, data_par,
                  input  ready, resp_data, resp_code, resp_valid, resp_count, resp_par);
  modport slave  (input  data, valid, resp_ready, data_par,
                  output ready, resp_data, resp_code, resp_valid, resp_count, resp_par);
`else
  modport master (output data, valid, resp_ready,
                  input  ready, resp_data, resp_code, resp_valid, resp_count);
  modport slave  (input  data, valid, resp_ready,
                  output ready, resp_data, resp_code, resp_valid, resp_count);
`endif
endinterface

// File: rtl/hs_resp_slave_sync_fifo.sv
// Synchronous FIFO, power-of-two DEPTH, async active-high reset.
// count_next is exported so the owner can register a look-ahead ready.
module hs_sync_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count,
  output logic [CW-1:0]    count_next
);
  logic [DEPTH-1:0][WIDTH-1:0] mem_q;
  logic [AW-1:0]               wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]               count_q, count_d;
  logic                        push_ok, pop_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_comb begin
    count_d = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop_ok) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  assign rdata      = mem_q[rd_ptr_q];
  assign count      = count_q;
  assign count_next = count_d;
endmodule

// File: rtl/hs_resp_slave.sv
// Response slave: accepts beats, range-checks them, returns one status beat each.
// Optional parity checking/generation under HS_RESP_PARITY_EN.
module hs_resp_slave
  import hs_pkg::*;
#(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] ADDR_BASE = 32'h1000_0000,
  parameter logic [31:0] ADDR_SIZE = 32'h0001_0000
) (
  input  logic            clk,
  input  logic            reset,
  hs_resp_slave_if.slave  bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  // 33-bit window so BASE+SIZE carrying past 2^32 still covers up to 32'hFFFF_FFFF.
  localparam logic [32:0] WIN_LO = {1'b0, ADDR_BASE};
  localparam logic [32:0] WIN_HI = {1'b0, ADDR_BASE} + {1'b0, ADDR_SIZE};

  logic          ready_q, ready_d;
  logic          in_range, bad_beat;
  resp_t         code;
  logic          push, pop, full, empty;
  logic [CW-1:0] count, count_next;
  logic [33:0]   rdata;

  assign in_range = ({1'b0, bus.data} >= WIN_LO) && ({1'b0, bus.data} < WIN_HI);
`ifdef HS_RESP_PARITY_EN
  assign bad_beat = !in_range || (even_par(bus.data) != bus.data_par);
`else
  assign bad_beat = !in_range;
`endif
  assign code = bad_beat ? RESP_SLVERR : RESP_OKAY;

  assign push = bus.valid && ready_q;
  assign pop  = bus.resp_valid && bus.resp_ready;

  hs_sync_fifo #(.WIDTH(34), .DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .wdata      ({code, bus.data}),
    .pop        (pop),
    .rdata      (rdata),
    .full       (full),
    .empty      (empty),
    .count      (count),
    .count_next (count_next)
  );

  // Registered look-ahead ready: a pop frees a slot only from the next cycle.
  assign ready_d = (count_next < CW'(DEPTH));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ready_q <= 1'b0;
    else       ready_q <= ready_d;
  end

  assign bus.ready      = ready_q;
  assign bus.resp_valid = !empty;
  assign bus.resp_data  = rdata[31:0];
  assign bus.resp_code  = rdata[33:32];
  assign bus.resp_count = count;
`ifdef HS_RESP_PARITY_EN
  assign bus.resp_par   = even_par(bus.resp_data);
`endif

  logic unused_full;
  assign unused_full = full;
endmodule

// File: tb/tb_hs_resp_slave.sv
// Scoreboard bench for hs_resp_slave (default DEPTH/window; parity cases under HS_RESP_PARITY_EN).
module tb_hs_resp_slave;
  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [33:0] exp_q[$];
  logic [33:0] mon_e;

  always #5 clk = ~clk;

  hs_resp_slave_if #(.DEPTH(4)) bus();
  hs_resp_slave #(.DEPTH(4)) dut (.clk(clk), .reset(reset), .bus(bus));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] ref_code(input logic [31:0] d, input logic bad_par);
    longint v;
    logic   legal;
    v     = longint'(d);
    legal = (v >= 64'h1000_0000) && (v < 64'h1000_0000 + 64'h0001_0000);
    return (legal && !bad_par) ? 2'b00 : 2'b10;
  endfunction

  // Caller is positioned just after a posedge; returns just after the accepting edge.
  task automatic send(input logic [31:0] d, input logic bad_par);
    int n = 0;
    bus.data  = d;
    bus.valid = 1'b1;
`ifdef HS_RESP_PARITY_EN
    bus.data_par = (^d) ^ bad_par;
`endif
    do begin
      @(negedge clk);
      n++;
    end while (!bus.ready && n < 200);
    if (!bus.ready) begin
      chk("accept timeout", 0, 1);
      bus.valid = 1'b0;
      return;
    end
    exp_q.push_back({ref_code(d, bad_par), d});
    @(posedge clk); #1;
    bus.valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || bus.resp_valid) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain left", exp_q.size(), 0);
    chk("drain count", bus.resp_count, 0);
  endtask

  always @(negedge clk) begin
    if (!reset && bus.resp_valid && bus.resp_ready) begin
      if (exp_q.size() == 0) chk("spurious resp", 1, 0);
      else begin
        mon_e = exp_q.pop_front();
        chk("resp_data", bus.resp_data, mon_e[31:0]);
        chk("resp_code", bus.resp_code, mon_e[33:32]);
`ifdef HS_RESP_PARITY_EN
        chk("resp_par", bus.resp_par, ^mon_e[31:0]);
`endif
      end
    end
  end

  initial begin
    logic [31:0] bnd [5];
    bnd[0] = 32'h0FFF_FFFF; bnd[1] = 32'h1000_FFFF; bnd[2] = 32'h1001_0000;
    bnd[3] = 32'hFFFF_FFFF; bnd[4] = 32'h1000_0000;

    reset = 1'b1;
    bus.data = 32'h1000_0000;
    bus.valid = 1'b1;
    bus.resp_ready = 1'b0;
`ifdef HS_RESP_PARITY_EN
    bus.data_par = 1'b0;
`endif
    // reset held 100 ns with valid high
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      chk("rst ready", bus.ready, 0);
      chk("rst resp_valid", bus.resp_valid, 0);
    end
    chk("rst count", bus.resp_count, 0);
    chk("rst resp_data", bus.resp_data, 0);
    chk("rst resp_code", bus.resp_code, 0);
    @(negedge clk);
    reset = 1'b0;
    bus.valid = 1'b0;
    #1 chk("ready before edge", bus.ready, 0);
    @(posedge clk); #1;
    chk("ready after edge", bus.ready, 1);

    // legal beat, latency one cycle
    bus.resp_ready = 1'b1;
    send(32'h1000_0006, 1'b0);
    @(negedge clk);
    chk("latency resp_valid", bus.resp_valid, 1);
    @(posedge clk); #1;
    drain();

    // illegal beat and window boundaries
    send(32'h2022_0503, 1'b0);
    for (int i = 0; i < 5; i++) send(bnd[i], 1'b0);
    drain();

    // backpressure / full
    bus.resp_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(32'h1000_0000 + i, 1'b0);
    bus.data  = 32'h1000_0004;
    bus.valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("full ready", bus.ready, 0);
    chk("full count", bus.resp_count, 4);
    @(posedge clk); #1;
    bus.resp_ready = 1'b1;
    @(negedge clk);
    chk("no bypass ready", bus.ready, 0);
    @(posedge clk); #1;
    chk("rearm ready", bus.ready, 1);
    chk("rearm count", bus.resp_count, 3);
    exp_q.push_back({2'b00, 32'h1000_0004});
    @(posedge clk); #1;
    bus.valid = 1'b0;
    chk("5th accepted count", bus.resp_count, 3);
    drain();

    // simultaneous push/pop at count 2
    bus.resp_ready = 1'b0;
    send(32'h1000_00A0, 1'b0);
    send(32'h1000_00A1, 1'b0);
    chk("pp start count", bus.resp_count, 2);
    bus.resp_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      send(32'h1000_0100 + i, 1'b0);
      chk("pp count", bus.resp_count, 2);
    end
    drain();

    // mid-operation reset drops outstanding responses
    bus.resp_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(32'h1000_0200 + i, 1'b0);
    chk("pre-reset count", bus.resp_count, 3);
    #2 reset = 1'b1;
    #1;
    chk("async rst resp_valid", bus.resp_valid, 0);
    chk("async rst count", bus.resp_count, 0);
    chk("async rst ready", bus.ready, 0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("post-rst ready", bus.ready, 1);
    bus.resp_ready = 1'b1;
    send(32'h1000_0300, 1'b0);
    drain();

`ifdef HS_RESP_PARITY_EN
    send(32'h1000_0010, 1'b1);
    send(32'h1000_0011, 1'b0);
    send(32'h2000_0000, 1'b1);
    drain();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/hs_resp_slave.md
Name: hs_resp_slave

Overview:
Receiving end of the 32-bit valid/ready data channel, plus the return path back to the master. Every accepted beat is buffered in a small FIFO. For each beat the block sends one response beat (status + echoed data) on a reverse valid/ready channel. This gives masters AXI-B-style write acknowledgement with a range check on the carried word.

Parameters:
DEPTH, 4, FIFO entries; power of 2, at least 2
ADDR_BASE, 32'h1000_0000, lowest legal value of the data word
ADDR_SIZE, 32'h0001_0000, legal window size; legal iff ADDR_BASE <= data < ADDR_BASE+ADDR_SIZE

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
data  input  32  forward data from master
valid  input  1  forward valid from master
ready  output  1  forward ready to master
resp_data  output  32  echoed data of the beat being acknowledged
resp_code  output  2  00 OKAY, 10 SLVERR
resp_valid  output  1  response valid
resp_ready  input  1  response ready from master
resp_count  output  $clog2(DEPTH)+1  outstanding responses (FIFO occupancy)

Behaviour:
- Reset: ready=0, resp_valid=0, resp_data=0, resp_code=00, resp_count=0; FIFO pointers cleared. ready rises on the first clk edge after reset deasserts.
- Forward accept: a transfer occurs on a clk edge where valid && ready. Data is sampled at that edge. Range-check result is computed combinationally and stored with the data.
- Range check: 33-bit compare, so that ADDR_BASE+ADDR_SIZE overflowing 2^32 is legal; the window then extends to 32'hFFFF_FFFF.
- ready is registered: ready = (count_next < DEPTH). No combinational path from resp_ready to ready.
- Full: ready=0. A pop in the same cycle that count reaches DEPTH re-raises ready on the next cycle only, with no bypass.
- Response: resp_valid = (count != 0). resp_data and resp_code are the FIFO head, driven from registers.
- Latency: the earliest response is the cycle after acceptance.
- Response pop occurs on resp_valid && resp_ready. resp_valid, resp_data and resp_code stay stable until the pop.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Empty with push: resp_valid asserts the next cycle; there is no same-cycle pass-through.
- Pointers wrap modulo DEPTH. count ranges 0..DEPTH and is never exceeded.
- Reset mid-operation clears all state immediately. Outstanding responses are dropped and not replayed.
- Protocol input assumptions enforced by the bench, not the RTL: valid/data held stable while valid && !ready.

Optional Feature:
HS_RESP_PARITY_EN
- Defined: extra input data_par (1), the even parity of data. A mismatch at acceptance forces resp_code=10 regardless of the range check.
- Defined: extra output resp_par (1), the even parity of resp_data.
- Undefined: neither port exists; resp_code comes from the range check only.

Decomposition:
- Package hs_pkg: RESP_OKAY=2'b00, RESP_SLVERR=2'b10, typedef resp_t (2-bit), typedef hs_word_t (32-bit), function even_par(hs_word_t).
- One sub-module, hs_sync_fifo (WIDTH, DEPTH): push/pop/full/empty/count, asynchronous active-high reset.
- Top level holds the range check, parity logic and ready register.

Test Plan:
- Reset: assert reset 100 ns with valid=1 -> ready=0 and resp_valid=0 throughout; ready=1 one clk edge after release.
- Legal beat: data=32'h1000_0006, valid one cycle, resp_ready=1 -> resp_valid the next cycle, resp_data=32'h1000_0006, resp_code=00, then resp_count returns to 0.
- Illegal beat: data=32'h2022_0503 -> response code 10, resp_data=32'h2022_0503.
- Backpressure/full: resp_ready=0, push 5 beats (32'h1000_0000..4) with DEPTH=4 -> 4 accepted, ready=0, the fifth held. Raise resp_ready: responses come out in order with codes 00, and the fifth beat is accepted one cycle after the first pop.
- Simultaneous push/pop at count=2 over 10 cycles -> count stays 2, ordering preserved, no loss or duplication.
- Mid-operation reset with 3 outstanding responses -> resp_valid drops asynchronously, count=0. Parity build: a corrupt data_par on a legal word gives code 10.
